// File: rtl/lpc_synth.sv
// LPC synthesis stage: pulse/noise excitation through a 10th-order all-pole IIR,
// one tap per clock on a single MAC, one output sample per accepted sample_tick.
module lpc_synth #(
  parameter int unsigned ORDER     = 10,
  parameter int unsigned COEF_FRAC = 13,
  parameter int unsigned ACC_W     = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  frame_valid,
  input  logic [ORDER*16-1:0]   coefs,
  input  logic                  voiced,
  input  logic [15:0]           pitch_period,
  input  logic [14:0]           gain,
  output logic signed [15:0]    y,
  output logic                  y_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned TAP_W = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(ORDER - 1);
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -ACC_W'(32768);

  typedef enum logic [1:0] {IDLE, EXC, MAC, OUT} state_t;

  state_t                     state_q, state_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [15:0]         hist_q [ORDER];
  logic signed [15:0]         hist_d [ORDER];
  logic [15:0]                lfsr_q, lfsr_d;
  logic [15:0]                pc_q, pc_d;
  logic signed [15:0]         y_q, y_d;
  logic                       y_valid_q, y_valid_d;
  logic                       overrun_q, overrun_d;

  logic [ORDER*16-1:0]        sh_coefs_q, sh_coefs_d, act_coefs_q, act_coefs_d;
  logic                       sh_voiced_q, sh_voiced_d, act_voiced_q, act_voiced_d;
  logic [15:0]                sh_pp_q, sh_pp_d, act_pp_q, act_pp_d;
  logic [14:0]                sh_gain_q, sh_gain_d, act_gain_q, act_gain_d;

  logic signed [31:0]         noise_prod;
  logic signed [31:0]         tap_prod;
  logic signed [ACC_W-1:0]    rnd;
  logic signed [ACC_W-1:0]    shr;
  logic signed [15:0]         ysat;
  logic [15:0]                exc;

  assign noise_prod = $signed(lfsr_q) * $signed({1'b0, act_gain_q});
  assign tap_prod   = $signed(act_coefs_q[16*tap_q +: 16]) * hist_q[tap_q];
  assign rnd        = acc_q + RND_HALF;
  assign shr        = rnd >>> COEF_FRAC;

  always_comb begin
    if (shr > SAT_MAX)      ysat = 16'sh7FFF;
    else if (shr < SAT_MIN) ysat = -16'sh8000;
    else                    ysat = 16'(shr);
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    acc_d        = acc_q;
    hist_d       = hist_q;
    lfsr_d       = lfsr_q;
    pc_d         = pc_q;
    y_d          = y_q;
    y_valid_d    = 1'b0;
    overrun_d    = overrun_q;
    sh_coefs_d   = sh_coefs_q;
    sh_voiced_d  = sh_voiced_q;
    sh_pp_d      = sh_pp_q;
    sh_gain_d    = sh_gain_q;
    act_coefs_d  = act_coefs_q;
    act_voiced_d = act_voiced_q;
    act_pp_d     = act_pp_q;
    act_gain_d   = act_gain_q;
    exc          = '0;

    if (frame_valid) begin
      sh_coefs_d  = coefs;
      sh_voiced_d = voiced;
      sh_pp_d     = pitch_period;
      sh_gain_d   = gain;
    end

    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          // sh_*_d already reflects a same-cycle frame_valid
          act_coefs_d  = sh_coefs_d;
          act_voiced_d = sh_voiced_d;
          act_pp_d     = sh_pp_d;
          act_gain_d   = sh_gain_d;
          state_d      = EXC;
        end
      end
      EXC: begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (!act_voiced_q) begin
          exc  = 16'(noise_prod >>> 15);
          pc_d = '0;
        end else if (act_pp_q == '0) begin
          pc_d = '0;
        end else if (pc_q == '0) begin
          exc  = {1'b0, act_gain_q};
          pc_d = act_pp_q - 16'd1;
        end else begin
          pc_d = pc_q - 16'd1;
        end
        acc_d   = {{(ACC_W-16-COEF_FRAC){exc[15]}}, exc, {COEF_FRAC{1'b0}}};
        tap_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q - {{(ACC_W-32){tap_prod[31]}}, tap_prod};
        if (tap_q == LAST_TAP) state_d = OUT;
        else                   tap_d   = tap_q + TAP_W'(1);
      end
      OUT: begin
        y_d       = ysat;
        y_valid_d = 1'b1;
        hist_d[0] = ysat;
        for (int unsigned i = 1; i < ORDER; i++) hist_d[i] = hist_q[i-1];
        state_d   = IDLE;
      end
    endcase

    if (sample_tick && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      acc_q        <= '0;
      hist_q       <= '{default: '0};
      lfsr_q       <= LFSR_SEED;
      pc_q         <= '0;
      y_q          <= '0;
      y_valid_q    <= 1'b0;
      overrun_q    <= 1'b0;
      sh_coefs_q   <= '0;
      sh_voiced_q  <= 1'b0;
      sh_pp_q      <= '0;
      sh_gain_q    <= '0;
      act_coefs_q  <= '0;
      act_voiced_q <= 1'b0;
      act_pp_q     <= '0;
      act_gain_q   <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      acc_q        <= acc_d;
      hist_q       <= hist_d;
      lfsr_q       <= lfsr_d;
      pc_q         <= pc_d;
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      overrun_q    <= overrun_d;
      sh_coefs_q   <= sh_coefs_d;
      sh_voiced_q  <= sh_voiced_d;
      sh_pp_q      <= sh_pp_d;
      sh_gain_q    <= sh_gain_d;
      act_coefs_q  <= act_coefs_d;
      act_voiced_q <= act_voiced_d;
      act_pp_q     <= act_pp_d;
      act_gain_q   <= act_gain_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule
